mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 16 +
 rtl/mem_port_arbiter_latency_counter.sv | 27 ++
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM encoding, owner codes, counter width.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } arb_state_t;

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_DM = 1'b1;

   // Wide enough for the largest legal latency (15).
   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_latency_counter.sv
// Memory latency down-counter: load, decrement towards zero, terminal-count flag.
module arb_latency_counter
   import mem_port_arbiter_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one single-ported memory.
// Optional macro ARB_ROUND_ROBIN_EN: alternate grants on contention instead of fixed DM priority.
//
// state  | meaning
// IDLE   | waiting for a request; grant and latch the winner on the next edge
// ACCESS | memory busy; MemEn pulses in the first cycle, read data captured at count 0
// RESP   | one cycle; owner's stall drops, then back to IDLE
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY = 2,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic [DATA_W-1:0] o_if_rdata,
   output logic              o_if_stall,
   input  logic              i_dm_req,
   input  logic              i_dm_write,
   input  logic [ADDR_W-1:0] i_dm_addr,
   input  logic [DATA_W-1:0] i_dm_wdata,
   output logic [DATA_W-1:0] o_dm_rdata,
   output logic              o_dm_stall,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_grant_owner
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY - 1);

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   logic              r_grant_owner;
   logic              r_wr;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_if_rdata;
   logic [DATA_W-1:0] r_dm_rdata;

   logic              w_any_req;
   logic              w_grant_dm;
   logic              w_grant;
   logic              w_cnt_dec;
   logic              w_cnt_zero;
   logic              w_capture;

   assign w_any_req = i_if_req | i_dm_req;

`ifdef ARB_ROUND_ROBIN_EN
   // On contention the port that did not own the last access wins.
   assign w_grant_dm = i_dm_req & (~i_if_req | (r_grant_owner == OWNER_IF));
`else
   assign w_grant_dm = i_dm_req;
`endif

   arb_latency_counter u_cnt (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (w_grant),
      .i_load_val (LOAD_VAL),
      .i_dec      (w_cnt_dec),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_grant      = 1'b0;
      w_cnt_dec    = 1'b0;
      w_capture    = 1'b0;
      o_if_stall   = i_if_req;
      o_dm_stall   = i_dm_req;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_grant      = 1'b1;
               w_next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            w_cnt_dec = 1'b1;
            if (w_cnt_zero) begin
               w_capture    = ~r_wr;
               w_next_state = ST_RESP;
            end
         end
         ST_RESP: begin
            o_if_stall   = i_if_req & (r_grant_owner != OWNER_IF);
            o_dm_stall   = i_dm_req & (r_grant_owner != OWNER_DM);
            w_next_state = ST_IDLE;
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_grant_owner <= OWNER_IF;
         r_wr          <= 1'b0;
         r_mem_en      <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_if_rdata    <= '0;
         r_dm_rdata    <= '0;
      end else begin
         r_mem_en <= w_grant;
         r_mem_we <= w_grant & w_grant_dm & i_dm_write;
         if (w_grant) begin
            r_grant_owner <= w_grant_dm ? OWNER_DM : OWNER_IF;
            r_wr          <= w_grant_dm & i_dm_write;
            r_mem_addr    <= w_grant_dm ? i_dm_addr : i_if_addr;
            r_mem_wdata   <= w_grant_dm ? i_dm_wdata : '0;
         end
         if (w_capture) begin
            if (r_grant_owner == OWNER_DM) begin
               r_dm_rdata <= i_mem_rdata;
            end else begin
               r_if_rdata <= i_mem_rdata;
            end
         end
      end
   end

   assign o_mem_en      = r_mem_en;
   assign o_mem_we      = r_mem_we;
   assign o_mem_addr    = r_mem_addr;
   assign o_mem_wdata   = r_mem_wdata;
   assign o_if_rdata    = r_if_rdata;
   assign o_dm_rdata    = r_dm_rdata;
   assign o_grant_owner = r_grant_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model plus directed scenarios.
// Honours ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        dm_req = 1'b0;
   logic        dm_write = 1'b0;
   logic [31:0] dm_addr = '0;
   logic [31:0] dm_wdata = '0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;
   logic        o_if_stall, o_dm_stall, o_mem_en, o_mem_we, o_grant_owner;

   // second instance at latency 1
   logic        rst1_n = 1'b0;
   logic        dm_req1 = 1'b0;
   logic [31:0] mem_rdata1;
   logic [31:0] if_rdata1, dm_rdata1, mem_addr1, mem_wdata1;
   logic        if_stall1, dm_stall1, mem_en1, mem_we1, grant1;

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(o_if_rdata), .o_if_stall(o_if_stall),
      .i_dm_req(dm_req), .i_dm_write(dm_write), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
      .o_dm_rdata(o_dm_rdata), .o_dm_stall(o_dm_stall),
      .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
      .i_mem_rdata(mem_rdata), .o_grant_owner(o_grant_owner));

   mem_port_arbiter #(.MEM_LATENCY(1), .ADDR_W(32), .DATA_W(32)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst1_n),
      .i_if_req(1'b0), .i_if_addr(32'h0), .o_if_rdata(if_rdata1), .o_if_stall(if_stall1),
      .i_dm_req(dm_req1), .i_dm_write(1'b0), .i_dm_addr(32'h8), .i_dm_wdata(32'h0),
      .o_dm_rdata(dm_rdata1), .o_dm_stall(dm_stall1),
      .o_mem_en(mem_en1), .o_mem_we(mem_we1), .o_mem_addr(mem_addr1), .o_mem_wdata(mem_wdata1),
      .i_mem_rdata(mem_rdata1), .o_grant_owner(grant1));

   assign mem_rdata1 = (mem_en1 && mem_addr1 == 32'h8) ? 32'h5 : 32'hFFFF_FFFF;

   int checks = 0;
   int failures = 0;

   // physical memory (driven by DUT) and model memory (driven by the model)
   logic [31:0] phys_mem  [256];
   logic [31:0] model_mem [256];

   // reference model: busy cycles remaining per access = LAT access cycles + 1 response cycle
   int          m_rem;
   logic        m_owner, m_wr;
   logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic set_mem(input int idx, input logic [31:0] val);
      phys_mem[idx]  = val;
      model_mem[idx] = val;
   endtask

   task automatic model_reset();
      m_rem = 0; m_owner = 1'b0; m_wr = 1'b0;
      m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
   endtask

   task automatic model_step();
      logic dm_wins;
      if (m_rem == 0) begin
         if (if_req || dm_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            dm_wins = dm_req && (!if_req || m_owner == 1'b0);
`else
            dm_wins = dm_req;
`endif
            m_owner = dm_wins;
            m_addr  = dm_wins ? dm_addr : if_addr;
            m_wr    = dm_wins && dm_write;
            m_wdata = dm_wins ? dm_wdata : 32'h0;
            if (m_wr) model_mem[m_addr[9:2]] = m_wdata;
            m_rem = LAT + 1;
         end
      end else begin
         if (m_rem == 2 && !m_wr) begin
            if (m_owner) m_dm_rdata = model_mem[m_addr[9:2]];
            else         m_if_rdata = model_mem[m_addr[9:2]];
         end
         m_rem--;
      end
   endtask

   task automatic compare_all();
      logic resp;
      resp = (m_rem == 1);
      chk("if_stall", {31'b0, o_if_stall}, {31'b0, if_req && !(resp && m_owner == 1'b0)});
      chk("dm_stall", {31'b0, o_dm_stall}, {31'b0, dm_req && !(resp && m_owner == 1'b1)});
      chk("mem_en",   {31'b0, o_mem_en},   {31'b0, m_rem == LAT + 1});
      chk("mem_we",   {31'b0, o_mem_we},   {31'b0, (m_rem == LAT + 1) && m_wr});
      chk("mem_addr", o_mem_addr, m_addr);
      chk("mem_wdata", o_mem_wdata, m_wdata);
      chk("grant_owner", {31'b0, o_grant_owner}, {31'b0, m_owner});
      chk("if_rdata", o_if_rdata, m_if_rdata);
      chk("dm_rdata", o_dm_rdata, m_dm_rdata);
   endtask

   logic tb_rst = 1'b0;

   task automatic cycle(input logic ifr, input logic [31:0] ifa, input logic dmr,
                        input logic dmw, input logic [31:0] dma, input logic [31:0] dmd);
      @(negedge clk);
      rst_n = tb_rst;
      if_req = ifr; if_addr = ifa; dm_req = dmr; dm_write = dmw; dm_addr = dma; dm_wdata = dmd;
      #1;
      if (!tb_rst) model_reset();
      compare_all();
      if (tb_rst) model_step();
   endtask

   // memory: read data valid only in the LAT-th cycle after the strobe, junk otherwise
   initial begin
      int          midx;
      logic [31:0] maddr;
      midx = -1;
      maddr = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) midx = -1;
         else if (o_mem_en) begin
            midx = 0;
            maddr = o_mem_addr;
            if (o_mem_we) phys_mem[o_mem_addr[9:2]] = o_mem_wdata;
         end else if (midx >= 0) midx++;
         mem_rdata = (midx == LAT - 1) ? phys_mem[maddr[9:2]] : ($urandom() | 32'h8000_0001);
      end
   end

   initial begin
      int          cnt, cnt2;
      logic        dm_pend;
      logic        owners [$];
      logic [31:0] ra;
      for (int i = 0; i < 256; i++) set_mem(i, 32'h1000_0000 + i * 32'h0001_0203);
      model_reset();

      // reset state
      tb_rst = 1'b0;
      cycle(0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      tb_rst = 1'b1;

      // instruction fetch, latency 2
      set_mem(16, 32'h8C22_0004);
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(1, 32'h40, 0, 0, 0, 0);
         if (o_if_stall) cnt++; else break;
      end
      chk("fetch_stall_cycles", cnt, 3);
      chk("fetch_rdata", o_if_rdata, 32'h8C22_0004);
      cycle(0, 0, 0, 0, 0, 0);

      // store
      cnt = 0; cnt2 = 0;
      for (int k = 0; k < 20; k++) begin
         cycle(0, 0, 1, 1, 32'h100, 32'hDEAD_BEEF);
         if (o_mem_en) begin
            cnt++;
            chk("store_addr", o_mem_addr, 32'h100);
            chk("store_wdata", o_mem_wdata, 32'hDEAD_BEEF);
         end
         if (o_mem_we) cnt2++;
         if (!o_dm_stall) break;
      end
      chk("store_en_pulses", cnt, 1);
      chk("store_we_pulses", cnt2, 1);
      chk("store_dm_rdata_kept", o_dm_rdata, 32'h0);
      cycle(0, 0, 0, 0, 0, 0);
      chk("store_mem_content", phys_mem[64], 32'hDEAD_BEEF);

      // reset during a load's ACCESS, then first request granted on first edge
      set_mem(2, 32'h0000_0005);
      cycle(0, 0, 1, 0, 32'h8, 0);
      tb_rst = 1'b0;
      cycle(0, 0, 1, 0, 32'h8, 0);
      chk("rst_mem_en", {31'b0, o_mem_en}, 32'h0);
      chk("rst_dm_rdata", o_dm_rdata, 32'h0);
      tb_rst = 1'b1;
      for (int k = 0; k < 3; k++) cycle(0, 0, 0, 0, 0, 0);
      chk("rst_no_capture", o_dm_rdata, 32'h0);
      cycle(0, 0, 1, 0, 32'h8, 0);
      cycle(0, 0, 1, 0, 32'h8, 0);
      chk("first_edge_grant", {31'b0, o_mem_en}, 32'h1);
      for (int k = 0; k < 10; k++) begin
         cycle(0, 0, 1, 0, 32'h8, 0);
         if (!o_dm_stall) break;
      end
      chk("load_rdata", o_dm_rdata, 32'h5);
      cycle(0, 0, 0, 0, 0, 0);

      // contention at reset release
      tb_rst = 1'b0;
      cycle(1, 32'h20, 1, 0, 32'h24, 0);
      tb_rst = 1'b1;
      cnt = 0; dm_pend = 1'b1; owners.delete();
      for (int k = 0; k < 30; k++) begin
         cycle(1, 32'h20, dm_pend, 0, 32'h24, 0);
         if (o_if_stall) cnt++;
         if (o_mem_en) owners.push_back(o_grant_owner);
         if (dm_pend && !o_dm_stall) dm_pend = 1'b0;
         if (!o_if_stall) break;
      end
      chk("contend_if_stall_cycles", cnt, 7);
      chk("contend_grants", owners.size(), 2);
      if (owners.size() == 2) begin
         chk("contend_first_owner", {31'b0, owners[0]}, 32'h1);
         chk("contend_second_owner", {31'b0, owners[1]}, 32'h0);
      end
      cycle(0, 0, 0, 0, 0, 0);

      // three back-to-back contentions
      tb_rst = 1'b0;
      cycle(0, 0, 0, 0, 0, 0);
      tb_rst = 1'b1;
      owners.delete();
      for (int k = 0; k < 40 && owners.size() < 3; k++) begin
         cycle(1, 32'h30, 1, 0, 32'h34, 0);
         if (o_mem_en) owners.push_back(o_grant_owner);
      end
      chk("b2b_grants", owners.size(), 3);
      if (owners.size() == 3) begin
`ifdef ARB_ROUND_ROBIN_EN
         chk("b2b_owner0", {31'b0, owners[0]}, 32'h1);
         chk("b2b_owner1", {31'b0, owners[1]}, 32'h0);
         chk("b2b_owner2", {31'b0, owners[2]}, 32'h1);
`else
         chk("b2b_owner0", {31'b0, owners[0]}, 32'h1);
         chk("b2b_owner1", {31'b0, owners[1]}, 32'h1);
         chk("b2b_owner2", {31'b0, owners[2]}, 32'h1);
`endif
      end
      for (int k = 0; k < 6; k++) cycle(0, 0, 0, 0, 0, 0);

      // randomized traffic with occasional reset pulses
      for (int k = 0; k < 3000; k++) begin
         tb_rst = ($urandom_range(0, 399) != 0);
         ra = $urandom_range(0, 15) * 4;
         cycle($urandom_range(0, 1) == 1, $urandom_range(0, 15) * 4,
               $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, ra, $urandom());
      end
      tb_rst = 1'b1;
      cycle(0, 0, 0, 0, 0, 0);

      // latency-1 instance: load from 0x8
      @(negedge clk);
      rst1_n = 1'b1;
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         dm_req1 = 1'b1;
         #1;
         if (dm_stall1) cnt++; else break;
      end
      chk("lat1_stall_cycles", cnt, 2);
      chk("lat1_rdata", dm_rdata1, 32'h5);
      @(negedge clk);
      dm_req1 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
